// File: rtl/bus_arb_pkg.sv
// Shared types and limits for the bus host arbiter and its in-order ID FIFO.
package bus_arb_pkg;

    localparam int MaxHostsLimit       = 4;
    localparam int MaxOutstandingLimit = 4;
    localparam int HostIdWidth         = $clog2(MaxHostsLimit);

    typedef logic [HostIdWidth-1:0] host_id_t;

    // FREE: winner chosen by round-robin; HOLD: a stalled winner keeps the bus.
    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side bus signals of the arbiter, bundled with modports.
// Handshake: a request transfers on a cycle where req and gnt are both 1; a
// response is a single-cycle rvalid pulse, returned in request order.
interface bus_host_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    logic [NrHosts-1:0]                   host_req_i;
    logic [NrHosts-1:0]                   host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
    logic [NrHosts-1:0]                   host_we_i;
    logic [NrHosts-1:0][BeWidth-1:0]      host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
    logic [NrHosts-1:0]                   host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;
    logic [NrHosts-1:0]                   host_err_o;

    logic                    dev_req_o;
    logic                    dev_gnt_i;
    logic [AddressWidth-1:0] dev_addr_o;
    logic                    dev_we_o;
    logic [BeWidth-1:0]      dev_be_o;
    logic [DataWidth-1:0]    dev_wdata_o;
    logic                    dev_rvalid_i;
    logic [DataWidth-1:0]    dev_rdata_i;
    logic                    dev_err_i;

    modport arb (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
    );

    modport env (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
    );

endinterface

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted host IDs; the head names the host owed the next response.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter  int Depth = 2,
    localparam int CntW  = $clog2(Depth + 1),
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  host_id_t        push_id_i,
    input  logic            pop_i,
    output host_id_t        head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    host_id_t        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id_i;
            end
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one pipelined device among NrHosts hosts, routing
// in-order responses back through an ID FIFO.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NrHosts        = 2,
    parameter  int DataWidth      = 32,
    parameter  int AddressWidth   = 32,
    parameter  int MaxOutstanding = 2,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    bus_host_arbiter_if.arb  bus,
    output logic [CntW-1:0]  outstanding_o,
    output logic             protocol_err_o,
    output arb_state_e       arb_state_o
);

    arb_state_e      state_q, state_d;
    host_id_t        last_q, last_d;
    host_id_t        hold_id_q, hold_id_d;
    logic            perr_q, perr_d;

    host_id_t        rr_winner;
    host_id_t        winner;
    logic            rr_found;
    logic            held_req;
    logic            any_req;
    logic            can_accept;
    logic            dev_req;
    logic            handshake;
    logic            resp_ok;

    host_id_t        fifo_head;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    // Round-robin search starting one past the last granted host.
    always_comb begin
        rr_winner = last_q;
        rr_found  = 1'b0;
        held_req  = 1'b0;
        for (int i = 0; i < NrHosts; i++) begin
            for (int j = 0; j < NrHosts; j++) begin
                if (!rr_found && bus.host_req_i[j] &&
                    (j == (int'(last_q) + 1 + i) % NrHosts)) begin
                    rr_winner = host_id_t'(j);
                    rr_found  = 1'b1;
                end
            end
        end
        for (int j = 0; j < NrHosts; j++) begin
            if (hold_id_q == host_id_t'(j)) begin
                held_req = bus.host_req_i[j];
            end
        end
    end

    assign any_req = |bus.host_req_i;
    assign winner  = (state_q == ARB_HOLD && held_req) ? hold_id_q : rr_winner;

    // dev_rvalid_i reaches dev_req only through the full-bypass term.
    assign can_accept = ~fifo_full | bus.dev_rvalid_i;
    assign dev_req    = rst_ni & any_req & can_accept;
    assign handshake  = dev_req & bus.dev_gnt_i;
    assign resp_ok    = bus.dev_rvalid_i & ~fifo_empty;

    always_comb begin
        bus.dev_req_o   = dev_req;
        bus.dev_addr_o  = '0;
        bus.dev_we_o    = 1'b0;
        bus.dev_be_o    = '0;
        bus.dev_wdata_o = '0;
        for (int j = 0; j < NrHosts; j++) begin
            bus.host_gnt_o[j]    = handshake && (winner == host_id_t'(j));
            bus.host_rvalid_o[j] = resp_ok && (fifo_head == host_id_t'(j));
            bus.host_err_o[j]    = resp_ok && (fifo_head == host_id_t'(j)) && bus.dev_err_i;
            bus.host_rdata_o[j]  = bus.dev_rdata_i;
            if (winner == host_id_t'(j)) begin
                bus.dev_addr_o  = bus.host_addr_i[j];
                bus.dev_we_o    = bus.host_we_i[j];
                bus.dev_be_o    = bus.host_be_i[j];
                bus.dev_wdata_o = bus.host_wdata_i[j];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        last_d    = last_q;
        perr_d    = perr_q | (bus.dev_rvalid_i & fifo_empty);
        if (handshake) begin
            last_d  = winner;
            state_d = ARB_FREE;
        end else if (dev_req) begin
            state_d   = ARB_HOLD;
            hold_id_d = winner;
        end else if (!held_req) begin
            state_d = ARB_FREE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_FREE;
            hold_id_q <= '0;
            last_q    <= host_id_t'(NrHosts - 1);
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            last_q    <= last_d;
            perr_q    <= perr_d;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (handshake),
        .push_id_i (winner),
        .pop_i     (resp_ok),
        .head_o    (fifo_head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign outstanding_o  = fifo_count;
    assign protocol_err_o = perr_q;
    assign arb_state_o    = state_q;

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter: arbitration order, stalls, response routing,
// full bypass, protocol error and asynchronous reset.
module tb_bus_host_arbiter;
    import bus_arb_pkg::*;

    localparam int NrHosts = 2;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int MaxOut  = 2;
    localparam int CntW    = $clog2(MaxOut + 1);

    localparam logic [AW-1:0] Addr0 = 32'h1000_0000;
    localparam logic [AW-1:0] Addr1 = 32'h2000_0010;

    logic            clk;
    logic            rst_n;
    logic [CntW-1:0] outstanding;
    logic            protocol_err;
    arb_state_e      arb_state;

    int total = 0;
    int bad   = 0;

    bus_host_arbiter_if #(.NrHosts(NrHosts), .DataWidth(DW), .AddressWidth(AW)) bus ();

    bus_host_arbiter #(
        .NrHosts        (NrHosts),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .outstanding_o  (outstanding),
        .protocol_err_o (protocol_err),
        .arb_state_o    (arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rdata, input logic err);
        bus.host_req_i   = req;
        bus.dev_gnt_i    = gnt;
        bus.dev_rvalid_i = rv;
        bus.dev_rdata_i  = rdata;
        bus.dev_err_i    = err;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.host_addr_i[0]  = Addr0;
        bus.host_addr_i[1]  = Addr1;
        bus.host_we_i       = 2'b10;
        bus.host_be_i[0]    = 4'hF;
        bus.host_be_i[1]    = 4'h3;
        bus.host_wdata_i[0] = 32'hCAFE_0000;
        bus.host_wdata_i[1] = 32'hBEEF_0001;
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        #10;
        chk("rst_dev_req", bus.dev_req_o, 0);
        chk("rst_gnt", bus.host_gnt_o, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_perr", protocol_err, 0);
        tick();
        rst_n = 1'b1;

        // Both hosts request continuously with a one-cycle response.
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        chk("alt_gnt_a", bus.host_gnt_o, 2'b01);
        chk("alt_addr_a", bus.dev_addr_o, Addr0);
        chk("alt_wdata_a", bus.dev_wdata_o, 32'hCAFE_0000);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        chk("alt_gnt_b", bus.host_gnt_o, 2'b10);
        chk("alt_addr_b", bus.dev_addr_o, Addr1);
        chk("alt_we_b", bus.dev_we_o, 1);
        chk("alt_be_b", bus.dev_be_o, 4'h3);
        chk("alt_rv_b", bus.host_rvalid_o, 2'b01);
        chk("alt_rdata_b", bus.host_rdata_o[0], 32'h0000_0100);
        tick();
        chk("alt_count_b", outstanding, 1);
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0101, 1'b0);
        chk("alt_gnt_c", bus.host_gnt_o, 2'b01);
        chk("alt_rv_c", bus.host_rvalid_o, 2'b10);
        chk("alt_rdata_c", bus.host_rdata_o[1], 32'h0000_0101);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
        chk("alt_gnt_d", bus.host_gnt_o, 2'b10);
        chk("alt_rv_d", bus.host_rvalid_o, 2'b01);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        chk("alt_rv_e", bus.host_rvalid_o, 2'b10);
        chk("alt_dev_req_idle", bus.dev_req_o, 0);
        tick();
        chk("alt_count_end", outstanding, 0);

        // Fill the response queue, then use the full bypass.
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        chk("full_gnt_1", bus.host_gnt_o, 2'b01);
        tick();
        chk("full_gnt_2", bus.host_gnt_o, 2'b01);
        tick();
        chk("full_count", outstanding, 2);
        chk("full_dev_req", bus.dev_req_o, 0);
        chk("full_gnt_none", bus.host_gnt_o, 2'b00);
        drive(2'b01, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("bypass_dev_req", bus.dev_req_o, 1);
        chk("bypass_gnt", bus.host_gnt_o, 2'b01);
        chk("bypass_rv", bus.host_rvalid_o, 2'b01);
        tick();
        chk("bypass_count", outstanding, 2);
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0201, 1'b0);
        tick();
        tick();
        chk("drain_count", outstanding, 0);

        // Host1 stalls three cycles with host0 also requesting.
        drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
        chk("stall_dev_req", bus.dev_req_o, 1);
        chk("stall_gnt_1", bus.host_gnt_o, 2'b00);
        chk("stall_addr_1", bus.dev_addr_o, Addr1);
        tick();
        chk("stall_state", arb_state, ARB_HOLD);
        chk("stall_addr_2", bus.dev_addr_o, Addr1);
        tick();
        chk("stall_addr_3", bus.dev_addr_o, Addr1);
        tick();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        chk("stall_gnt_4", bus.host_gnt_o, 2'b10);
        tick();
        chk("stall_next", bus.host_gnt_o, 2'b01);
        tick();

        // In-order responses with per-host data and error.
        drive(2'b00, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
        chk("resp1_rv", bus.host_rvalid_o, 2'b10);
        chk("resp1_rdata", bus.host_rdata_o[1], 32'hA5A5_0001);
        chk("resp1_err", bus.host_err_o, 2'b00);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h5A5A_0002, 1'b1);
        chk("resp2_rv", bus.host_rvalid_o, 2'b01);
        chk("resp2_rdata", bus.host_rdata_o[0], 32'h5A5A_0002);
        chk("resp2_err", bus.host_err_o, 2'b01);
        tick();
        chk("resp_count", outstanding, 0);

        // A stalled winner keeps the bus even when a higher-priority host arrives.
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
        chk("hold_gnt_pre", bus.host_gnt_o, 2'b10);
        tick();
        drive(2'b10, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
        chk("hold_rv_pre", bus.host_rvalid_o, 2'b10);
        tick();
        drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
        chk("hold_addr", bus.dev_addr_o, Addr1);
        tick();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        chk("hold_gnt", bus.host_gnt_o, 2'b10);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0301, 1'b0);
        chk("hold_rv", bus.host_rvalid_o, 2'b10);
        tick();

        // Unexpected response with nothing outstanding.
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_0000, 1'b1);
        chk("perr_rv", bus.host_rvalid_o, 2'b00);
        chk("perr_before", protocol_err, 0);
        tick();
        chk("perr_set", protocol_err, 1);
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();
        chk("perr_sticky", protocol_err, 1);

        // Asynchronous reset with two transactions outstanding.
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        tick();
        tick();
        chk("pre_rst_count", outstanding, 2);
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        #1;
        rst_n = 1'b0;
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
        chk("arst_count", outstanding, 0);
        chk("arst_perr", protocol_err, 0);
        chk("arst_dev_req", bus.dev_req_o, 0);
        chk("arst_gnt", bus.host_gnt_o, 2'b00);
        chk("arst_rv", bus.host_rvalid_o, 2'b00);
        chk("arst_err", bus.host_err_o, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0401, 1'b0);
        chk("post_rst_gnt", bus.host_gnt_o, 2'b01);
        chk("post_rst_addr", bus.dev_addr_o, Addr0);
        chk("post_rst_rv", bus.host_rvalid_o, 2'b00);
        tick();
        chk("post_rst_count", outstanding, 1);
        chk("post_rst_perr", protocol_err, 1);
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0402, 1'b0);
        chk("post_rst_rv2", bus.host_rvalid_o, 2'b01);
        tick();
        chk("post_rst_count2", outstanding, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
